reg_file_rename: RTL and testbench
==================================

Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags.
- Sits directly downstream of the reorder buffer: consumes its commit write-back (register index, ROB tag, value) and its misbranch flush.
- Serves the decoder: for each source register it returns either a committed value or the ROB tag that will produce the value.
- The decoder writes a new rename tag each time it dispatches an instruction with a destination register.

Parameters:
DATA_W, 32, data width
REG_W, 5, register index width (2^REG_W registers)
ROB_W, 4, ROB tag width; tag 0 means "no pending producer"

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  global enable; when low, no state changes
in_commit_reg  in  REG_W  ROB commit destination register; 0 means no commit
in_commit_rob  in  ROB_W  ROB tag of the committing entry
in_commit_value  in  DATA_W  committed value
in_misbranch  in  1  ROB flush: discard all rename tags
in_rename_ena  in  1  decoder dispatches an instruction with a destination register
in_rename_reg  in  REG_W  destination register being renamed
in_rename_rob  in  ROB_W  ROB tag allocated to that destination
in_query_reg1  in  REG_W  decoder source register 1
in_query_reg2  in  REG_W  decoder source register 2
out_value1  out  DATA_W  value for source 1 (valid when out_tag1==0)
out_tag1  out  ROB_W  pending producer tag for source 1; 0 means value is ready
out_value2  out  DATA_W  value for source 2 (valid when out_tag2==0)
out_tag2  out  ROB_W  pending producer tag for source 2; 0 means value is ready

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; it takes priority over ena.
- Reset: all values cleared to 0; all tags cleared to 0.
- Storage: value[0..2^REG_W-1] and tag[0..2^REG_W-1].
- Register 0: value and tag are hardwired to 0. Commits and renames to register 0 are ignored.
- Commit (ena=1, in_commit_reg!=0):
  - value[reg] <= in_commit_value, unconditionally.
  - tag[reg] <= 0 only if tag[reg]==in_commit_rob. Otherwise a younger rename is outstanding and the tag is kept.
- Rename (ena=1, in_rename_ena=1, in_rename_reg!=0, in_misbranch=0): tag[reg] <= in_rename_rob.
- Same-cycle rename and commit to the same register: rename wins for the tag; the value write still happens.
- Misbranch (ena=1, in_misbranch=1):
  - Every tag is cleared to 0.
  - A rename in the same cycle is discarded.
  - A commit in the same cycle still writes its value. The ROB asserts misbranch together with the JALR write-back, so that write is architecturally valid.
- ena=0: commit, rename and flush are all ignored; reads still operate.
- Reads are combinational with same-cycle commit bypass, evaluated in this order for each port:
  - Query register 0 -> value 0, tag 0.
  - Else, if ena=1, in_commit_reg==query and tag[query]==in_commit_rob -> value = in_commit_value, tag = 0.
  - Else, if ena=1 and in_misbranch=1 -> value = value[query], tag = 0.
  - Else -> value = value[query], tag = tag[query].
- Read-side rename bypass: none. A rename this cycle is visible to queries from the next cycle.
- No internal latency beyond the one-cycle state update; no handshake or back-pressure.
- Tag reuse: the ROB wraps tags, and tags are compared by equality only. Correctness relies on the ROB never having two live entries with the same tag.

Test Plan:
- Reset then query x5/x0 -> values 0, tags 0. Commit reg=0, value=0xDEAD -> x0 still reads 0.
- Rename x3->tag 4; next cycle query x3 -> tag 4. Commit x3/tag4/0x11 -> same cycle reads value 0x11, tag 0; next cycle tag[3]=0, value 0x11.
- Rename x3->4, then x3->7. Commit x3/tag4/0x22 -> value[3]=0x22, tag[3] stays 7; query x3 returns tag 7.
- Same cycle: rename x6->9 and commit x6/tag9/0x33 (tag[6]=9 beforehand) -> after the edge tag[6]=9 (rename wins), value[6]=0x33.
- Renames on x1,x2,x4 pending; misbranch together with commit x1/tag(x1)/0x44 and rename x2->12 -> all tags 0, value[1]=0x44, rename dropped; in the misbranch cycle queries return tag 0.
- ena=0 with commit, rename and misbranch all asserted -> no state change; after ena=1 state matches the pre-stall values. Assert rst mid-sequence -> all values and tags 0 on the next cycle.

Source files
------------

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Combinational dual read port with same-cycle commit bypass; one commit, one rename and a flush per cycle.
module reg_file_rename #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [REG_W-1:0]  in_commit_reg,
    input  logic [ROB_W-1:0]  in_commit_rob,
    input  logic [DATA_W-1:0] in_commit_value,
    input  logic              in_misbranch,
    input  logic              in_rename_ena,
    input  logic [REG_W-1:0]  in_rename_reg,
    input  logic [ROB_W-1:0]  in_rename_rob,
    input  logic [REG_W-1:0]  in_query_reg1,
    input  logic [REG_W-1:0]  in_query_reg2,
    output logic [DATA_W-1:0] out_value1,
    output logic [ROB_W-1:0]  out_tag1,
    output logic [DATA_W-1:0] out_value2,
    output logic [ROB_W-1:0]  out_tag2
);

    localparam int NREG = 1 << REG_W;

    logic [DATA_W-1:0] value_q [NREG];
    logic [DATA_W-1:0] value_d [NREG];
    logic [ROB_W-1:0]  tag_q   [NREG];
    logic [ROB_W-1:0]  tag_d   [NREG];

    // Commit writes the value unconditionally; the tag clears only if no younger rename replaced it.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (ena) begin
            if (in_commit_reg != '0) begin
                value_d[in_commit_reg] = in_commit_value;
                if (tag_q[in_commit_reg] == in_commit_rob) begin
                    tag_d[in_commit_reg] = '0;
                end
            end
            if (in_misbranch) begin
                for (int i = 0; i < NREG; i++) begin
                    tag_d[i] = '0;
                end
            end else if (in_rename_ena && (in_rename_reg != '0)) begin
                tag_d[in_rename_reg] = in_rename_rob;
            end
        end
        value_d[0] = '0;
        tag_d[0]   = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    // Returns {value, tag} for one source register.
    function automatic logic [DATA_W+ROB_W-1:0] read_port(input logic [REG_W-1:0] q);
        logic [DATA_W-1:0] v;
        logic [ROB_W-1:0]  t;
        v = value_q[q];
        t = tag_q[q];
        if (q == '0) begin
            v = '0;
            t = '0;
        end else if (ena && (in_commit_reg == q) && (tag_q[q] == in_commit_rob)) begin
            v = in_commit_value;
            t = '0;
        end else if (ena && in_misbranch) begin
            t = '0;
        end
        return {v, t};
    endfunction

    always_comb begin
        {out_value1, out_tag1} = read_port(in_query_reg1);
        {out_value2, out_tag2} = read_port(in_query_reg2);
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: directed plan followed by randomized traffic
// checked against an array-based reference model of the register/tag state.
module tb_reg_file_rename;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ROB_W  = 4;
    localparam int NREG   = 1 << REG_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [REG_W-1:0]  in_commit_reg;
    logic [ROB_W-1:0]  in_commit_rob;
    logic [DATA_W-1:0] in_commit_value;
    logic              in_misbranch;
    logic              in_rename_ena;
    logic [REG_W-1:0]  in_rename_reg;
    logic [ROB_W-1:0]  in_rename_rob;
    logic [REG_W-1:0]  in_query_reg1;
    logic [REG_W-1:0]  in_query_reg2;
    logic [DATA_W-1:0] out_value1;
    logic [ROB_W-1:0]  out_tag1;
    logic [DATA_W-1:0] out_value2;
    logic [ROB_W-1:0]  out_tag2;

    reg_file_rename #(.DATA_W(DATA_W), .REG_W(REG_W), .ROB_W(ROB_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .in_commit_reg  (in_commit_reg),
        .in_commit_rob  (in_commit_rob),
        .in_commit_value(in_commit_value),
        .in_misbranch   (in_misbranch),
        .in_rename_ena  (in_rename_ena),
        .in_rename_reg  (in_rename_reg),
        .in_rename_rob  (in_rename_rob),
        .in_query_reg1  (in_query_reg1),
        .in_query_reg2  (in_query_reg2),
        .out_value1     (out_value1),
        .out_tag1       (out_tag1),
        .out_value2     (out_value2),
        .out_tag2       (out_tag2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic [REG_W-1:0]  q1;
        logic [REG_W-1:0]  q2;
        logic [DATA_W-1:0] v1;
        logic [ROB_W-1:0]  t1;
        logic [DATA_W-1:0] v2;
        logic [ROB_W-1:0]  t2;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference architectural state.
    logic [DATA_W-1:0] m_val [NREG];
    logic [ROB_W-1:0]  m_tag [NREG];

    task automatic model_read(input logic [REG_W-1:0] q, output logic [DATA_W-1:0] v,
                              output logic [ROB_W-1:0] t);
        if (q == 0) begin
            v = 0; t = 0;
        end else if (ena && in_commit_reg == q && m_tag[q] == in_commit_rob) begin
            v = in_commit_value; t = 0;
        end else if (ena && in_misbranch) begin
            v = m_val[q]; t = 0;
        end else begin
            v = m_val[q]; t = m_tag[q];
        end
    endtask

    task automatic model_update();
        logic [ROB_W-1:0] old_tag [NREG];
        old_tag = m_tag;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin m_val[i] = 0; m_tag[i] = 0; end
        end else if (ena) begin
            if (in_commit_reg != 0) begin
                m_val[in_commit_reg] = in_commit_value;
                if (old_tag[in_commit_reg] == in_commit_rob) m_tag[in_commit_reg] = 0;
            end
            if (in_misbranch) begin
                for (int i = 0; i < NREG; i++) m_tag[i] = 0;
            end else if (in_rename_ena && in_rename_reg != 0) begin
                m_tag[in_rename_reg] = in_rename_rob;
            end
        end
    endtask

    // Drive one cycle of inputs (#2 after the edge), log the expected reads, advance the model.
    task automatic step(input logic r, input logic e,
                        input logic [REG_W-1:0] cr, input logic [ROB_W-1:0] crob,
                        input logic [DATA_W-1:0] cv, input logic mb,
                        input logic ren, input logic [REG_W-1:0] rr, input logic [ROB_W-1:0] rrob,
                        input logic [REG_W-1:0] q1, input logic [REG_W-1:0] q2);
        exp_t x;
        #2;
        rst = r; ena = e; in_commit_reg = cr; in_commit_rob = crob; in_commit_value = cv;
        in_misbranch = mb; in_rename_ena = ren; in_rename_reg = rr; in_rename_rob = rrob;
        in_query_reg1 = q1; in_query_reg2 = q2;
        x.cyc = cyc; x.q1 = q1; x.q2 = q2;
        model_read(q1, x.v1, x.t1);
        model_read(q2, x.v2, x.t2);
        sbq.push_back(x);
        model_update();
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle_query(input logic [REG_W-1:0] q1, input logic [REG_W-1:0] q2);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    task automatic rename(input logic [REG_W-1:0] rr, input logic [ROB_W-1:0] rrob);
        step(0, 1, 0, 0, 0, 0, 1, rr, rrob, rr, 0);
    endtask

    // Monitor: outputs are valid every cycle, so compare whenever an expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_tests++;
                if (out_value1 !== e.v1 || out_tag1 !== e.t1) begin
                    n_fail++;
                    $display("FAIL port1 cyc=%0d q=%0d got val=%h tag=%0d exp val=%h tag=%0d",
                             e.cyc, e.q1, out_value1, out_tag1, e.v1, e.t1);
                end
                n_tests++;
                if (out_value2 !== e.v2 || out_tag2 !== e.t2) begin
                    n_fail++;
                    $display("FAIL port2 cyc=%0d q=%0d got val=%h tag=%0d exp val=%h tag=%0d",
                             e.cyc, e.q2, out_value2, out_tag2, e.v2, e.t2);
                end
            end
        end
    end

    initial begin
        logic [REG_W-1:0] cr, rr, q1, q2;
        logic [ROB_W-1:0] crob, rrob;
        rst = 1; ena = 0; in_commit_reg = 0; in_commit_rob = 0; in_commit_value = 0;
        in_misbranch = 0; in_rename_ena = 0; in_rename_reg = 0; in_rename_rob = 0;
        in_query_reg1 = 0; in_query_reg2 = 0;
        for (int i = 0; i < NREG; i++) begin m_val[i] = 0; m_tag[i] = 0; end
        repeat (2) @(posedge clk);

        // Reset state and register 0 immunity.
        idle_query(5, 0);
        step(0, 1, 0, 0, 32'hDEAD, 0, 0, 0, 0, 0, 5);
        idle_query(0, 0);

        // Rename then commit with bypass.
        rename(3, 4);
        idle_query(3, 0);
        step(0, 1, 3, 4, 32'h11, 0, 0, 0, 0, 3, 3);
        idle_query(3, 0);

        // Stale commit leaves the younger tag.
        rename(3, 4);
        rename(3, 7);
        step(0, 1, 3, 4, 32'h22, 0, 0, 0, 0, 3, 0);
        idle_query(3, 3);

        // Same-cycle rename and commit on one register.
        rename(6, 9);
        step(0, 1, 6, 9, 32'h33, 0, 1, 6, 9, 6, 0);
        idle_query(6, 0);

        // Misbranch with commit and a dropped rename.
        rename(1, 5);
        rename(2, 6);
        rename(4, 8);
        step(0, 1, 1, 5, 32'h44, 1, 1, 2, 12, 2, 4);
        idle_query(1, 2);
        idle_query(4, 0);

        // Stall, then reset mid-sequence.
        rename(5, 3);
        step(0, 0, 5, 3, 32'h99, 1, 1, 5, 10, 5, 1);
        idle_query(5, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 6);
        idle_query(1, 6);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cr   = ($urandom_range(0, 3) == 0) ? 5'd0 : REG_W'($urandom_range(0, NREG - 1));
            crob = ($urandom_range(0, 2) != 0) ? m_tag[cr] : ROB_W'($urandom_range(0, 15));
            rr   = REG_W'($urandom_range(0, NREG - 1));
            rrob = ROB_W'($urandom_range(1, 15));
            q1   = ($urandom_range(0, 1) != 0) ? cr : REG_W'($urandom_range(0, NREG - 1));
            q2   = REG_W'($urandom_range(0, NREG - 1));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, cr, crob, $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, rr, rrob, q1, q2);
        end

        #2;
        rst = 0; ena = 0;
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d exp 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
